// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl
// Byte-level sequencer that sits between the host register file and the I2C
// bit controller. A host command (start/read/write/stop flags plus a byte) is
// broken into bit-controller commands: an optional START, 8 data bits, 1 ACK
// bit and an optional STOP. Arbitration loss aborts the sequence to idle.
//
// Ports:
//   clk, nReset            clock, synchronous active-low reset
//   start/stop/read/write  host command flags, held stable until cmd_ack
//   ack_in                 ACK value to drive after a read (0 = ACK)
//   din                    byte to transmit
//   cmd_ack                one-cycle completion pulse
//   ack_out                ACK bit sampled in the ACK slot
//   dout                   received byte (the shift register itself)
//   bit_cmd, bit_txd       command and data bit to the bit controller
//   bit_ack, bit_al        bit-controller done pulse and arbitration lost
//   bit_rxd                data bit from the bit controller
module i2c_master_byte_ctrl #(
  parameter logic [3:0] CMD_NOP   = 4'b0000,
  parameter logic [3:0] CMD_START = 4'b0001,
  parameter logic [3:0] CMD_STOP  = 4'b0010,
  parameter logic [3:0] CMD_WRITE = 4'b0100,
  parameter logic [3:0] CMD_READ  = 4'b1000
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic [3:0] bit_cmd,
  input  logic       bit_ack,
  input  logic       bit_al,
  output logic       bit_txd,
  input  logic       bit_rxd
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_READ, ST_WRITE, ST_ACK, ST_STOP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cmd_n;
  logic        txd_n, cmd_ack_n, ack_out_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  dcnt, dcnt_n;
  logic        go;

  // Masking with cmd_ack stops a host that keeps its flags high from
  // relaunching in the very cycle it sees the completion pulse.
  assign go   = (read | write | stop) & ~cmd_ack;
  assign dout = shift;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      bit_cmd <= CMD_NOP;
      bit_txd <= 1'b0;
      shift   <= 8'h00;
      dcnt    <= 3'd0;
      cmd_ack <= 1'b0;
      ack_out <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cmd <= cmd_n;
      bit_txd <= txd_n;
      shift   <= shift_n;
      dcnt    <= dcnt_n;
      cmd_ack <= cmd_ack_n;
      ack_out <= ack_out_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_n     = bit_cmd;
    txd_n     = bit_txd;
    shift_n   = shift;
    dcnt_n    = dcnt;
    cmd_ack_n = 1'b0;
    ack_out_n = ack_out;

    if (bit_al) begin
      // Lost the bus: drop everything, keep shift/ack_out, no completion pulse.
      state_n = ST_IDLE;
      cmd_n   = CMD_NOP;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_n = CMD_NOP;
          if (go) begin
            shift_n = din;
            dcnt_n  = 3'd7;
            if (start) begin
              state_n = ST_START;
              cmd_n   = CMD_START;
            end else if (read) begin
              state_n = ST_READ;
              cmd_n   = CMD_READ;
            end else if (write) begin
              state_n = ST_WRITE;
              cmd_n   = CMD_WRITE;
              txd_n   = din[7];
            end else begin
              state_n = ST_STOP;
              cmd_n   = CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (bit_ack) begin
            if (read) begin
              state_n = ST_READ;
              cmd_n   = CMD_READ;
            end else begin
              state_n = ST_WRITE;
              cmd_n   = CMD_WRITE;
              txd_n   = shift[7];
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (bit_ack) begin
            shift_n = {shift[6:0], bit_rxd};
            if (dcnt != 3'd0) begin
              dcnt_n = dcnt - 3'd1;
              // shift[6] becomes the MSB once this bit is shifted out
              txd_n  = shift[6];
            end else begin
              state_n = ST_ACK;
              if (state == ST_READ) begin
                cmd_n = CMD_WRITE;
                txd_n = ack_in;
              end else begin
                // Release SDA and sample the slave's ACK
                cmd_n = CMD_READ;
                txd_n = 1'b1;
              end
            end
          end
        end

        ST_ACK: begin
          if (bit_ack) begin
            ack_out_n = bit_rxd;
            if (stop) begin
              state_n = ST_STOP;
              cmd_n   = CMD_STOP;
            end else begin
              state_n   = ST_IDLE;
              cmd_n     = CMD_NOP;
              cmd_ack_n = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (bit_ack) begin
            state_n   = ST_IDLE;
            cmd_n     = CMD_NOP;
            cmd_ack_n = 1'b1;
          end
        end

        default: begin
          state_n = ST_IDLE;
          cmd_n   = CMD_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Testbench for i2c_master_byte_ctrl. A bit-controller model acknowledges
// every command and records what it was given; a bit monitor and a completion
// monitor compare against expectation queues filled by the stimulus.
module tb_i2c_master_byte_ctrl;
  localparam logic [3:0] NOP = 4'b0000, STA = 4'b0001, STO = 4'b0010,
                         WR = 4'b0100, RD = 4'b1000;

  logic       clk = 1'b0;
  logic       nReset, start, stop, read, write, ack_in;
  logic [7:0] din, dout;
  logic       cmd_ack, ack_out;
  logic [3:0] bit_cmd;
  logic       bit_ack, bit_al, bit_txd, bit_rxd;

  always #5 clk = ~clk;

  i2c_master_byte_ctrl dut (
    .clk(clk), .nReset(nReset), .start(start), .stop(stop), .read(read),
    .write(write), .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack),
    .ack_out(ack_out), .dout(dout), .bit_cmd(bit_cmd), .bit_ack(bit_ack),
    .bit_al(bit_al), .bit_txd(bit_txd), .bit_rxd(bit_rxd)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  logic [4:0] exp_bit_q[$], obs_q[$];
  logic [8:0] exp_done_q[$];
  logic       rx_q[$];
  bit model_en = 1'b0;
  int al_at = -1, ack_cnt = 0, last_ack_cyc = -10, wcnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endfunction

  task automatic push_write(input logic [7:0] b, input logic slave_ack);
    for (int i = 7; i >= 0; i--) exp_bit_q.push_back({WR, b[i]});
    exp_bit_q.push_back({RD, 1'b0});
    rx_q.push_back(slave_ack);
  endtask

  task automatic push_read(input logic [7:0] b, input logic own_ack);
    for (int i = 7; i >= 0; i--) begin
      exp_bit_q.push_back({RD, 1'b0});
      rx_q.push_back(b[i]);
    end
    exp_bit_q.push_back({WR, own_ack});
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) return;
    end
    n_chk++;
    $display("FAIL %s: no cmd_ack within 400 cycles", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bit-controller model: acks each command on its second cycle.
  initial begin
    bit_ack = 1'b0; bit_al = 1'b0; bit_rxd = 1'b0;
    forever begin
      @(negedge clk);
      bit_ack = 1'b0;
      bit_al  = 1'b0;
      if (model_en && bit_cmd !== NOP && bit_cmd !== 4'bx) begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt = 0;
          ack_cnt++;
          bit_ack = 1'b1;
          last_ack_cyc = cyc;
          if (bit_cmd == RD) bit_rxd = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b1;
          else if (bit_cmd == WR) bit_rxd = bit_txd;
          else bit_rxd = 1'b1;
          obs_q.push_back({bit_cmd, bit_txd});
          if (ack_cnt == al_at) bit_al = 1'b1;
        end
      end else wcnt = 0;
    end
  end

  // Bit monitor
  initial forever begin
    logic [4:0] o, e;
    @(posedge clk);
    #1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_bit_q.size() == 0) begin
        n_chk++;
        $display("FAIL bit_cmd: unexpected command %0h txd %0b", o[4:1], o[0]);
      end else begin
        e = exp_bit_q.pop_front();
        if (e[4:1] == WR) chk("bit_cmd+txd", 32'(o), 32'(e));
        else chk("bit_cmd", 32'(o[4:1]), 32'(e[4:1]));
      end
    end
  end

  // Completion monitor
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (cmd_ack === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        n_chk++;
        $display("FAIL cmd_ack: unexpected pulse, dout %0h", dout);
      end else begin
        e = exp_done_q.pop_front();
        chk("dout/ack_out", 32'({dout, ack_out}), 32'(e));
      end
      chk("cmd_ack latency", 32'(cyc), 32'(last_ack_cyc + 1));
      chk("pulse-cycle bit_cmd", 32'(bit_cmd), 32'(NOP));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    nReset = 1'b0; start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset bit_cmd", 32'(bit_cmd), 32'(NOP));
    chk("reset bit_txd", 32'(bit_txd), 0);
    chk("reset dout", 32'(dout), 0);
    chk("reset ack_out", 32'(ack_out), 0);
    chk("reset cmd_ack", 32'(cmd_ack), 0);
    nReset = 1'b1;
    model_en = 1'b1;
    @(negedge clk);

    // Write A5 with START, slave ACKs
    exp_bit_q.push_back({STA, 1'b0});
    push_write(8'hA5, 1'b0);
    exp_done_q.push_back({8'hA5, 1'b0});
    din = 8'hA5; start = 1; write = 1;
    wait_done("write A5");
    start = 0; write = 0;
    @(negedge clk);

    // Read 6C, NACK, STOP
    push_read(8'h6C, 1'b1);
    exp_bit_q.push_back({STO, 1'b0});
    exp_done_q.push_back({8'h6C, 1'b1});
    read = 1; stop = 1; ack_in = 1;
    wait_done("read 6C");
    read = 0; stop = 0; ack_in = 0;
    @(negedge clk);

    // Stop only (din matches current dout so the byte is unchanged)
    exp_bit_q.push_back({STO, 1'b0});
    exp_done_q.push_back({8'h6C, 1'b1});
    din = 8'h6C; stop = 1;
    wait_done("stop only");
    stop = 0;
    @(negedge clk);

    // Arbitration loss on the 3rd write bit
    din = 8'h3C;
    exp_bit_q.push_back({WR, 1'b0});
    exp_bit_q.push_back({WR, 1'b0});
    exp_bit_q.push_back({WR, 1'b1});
    al_at = ack_cnt + 3;
    write = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bit_cmd == WR) seen = 1;
    end
    write = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      if (bit_al) seen = 1;
    end
    if (!seen) begin n_chk++; $display("FAIL arb: bit_al never raised"); end
    @(negedge clk);
    chk("arb bit_cmd", 32'(bit_cmd), 32'(NOP));
    chk("arb dout held", 32'(dout), 32'h F0);
    chk("arb cmd_ack", 32'(cmd_ack), 0);
    repeat (5) @(negedge clk);
    chk("arb stays idle", 32'(bit_cmd), 32'(NOP));
    al_at = -1;

    // New write accepted after loss, slave NACKs
    push_write(8'h81, 1'b1);
    exp_done_q.push_back({8'h81, 1'b1});
    din = 8'h81; write = 1;
    wait_done("write 81");
    write = 0;
    @(negedge clk);

    // Reset in the middle of a read
    exp_bit_q.push_back({RD, 1'b0});
    exp_bit_q.push_back({RD, 1'b0});
    exp_bit_q.push_back({RD, 1'b0});
    rx_q.push_back(1'b1); rx_q.push_back(1'b0); rx_q.push_back(1'b1);
    base = ack_cnt;
    read = 1; ack_in = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      if (ack_cnt >= base + 3) seen = 1;
    end
    if (!seen) begin n_chk++; $display("FAIL reset-mid: read bits not acked"); end
    #1;
    nReset = 0; model_en = 0; read = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset bit_cmd", 32'(bit_cmd), 32'(NOP));
    chk("midreset dout", 32'(dout), 0);
    chk("midreset ack_out", 32'(ack_out), 0);
    chk("midreset cmd_ack", 32'(cmd_ack), 0);
    rx_q.delete();
    nReset = 1; model_en = 1;
    repeat (5) @(negedge clk);
    chk("idle after reset", 32'(bit_cmd), 32'(NOP));

    // Back-to-back writes with write held across cmd_ack
    push_write(8'h5A, 1'b0);
    push_write(8'h5A, 1'b0);
    exp_done_q.push_back({8'h5A, 1'b0});
    exp_done_q.push_back({8'h5A, 1'b0});
    din = 8'h5A; write = 1;
    wait_done("b2b first");
    @(negedge clk);
    chk("b2b gap bit_cmd", 32'(bit_cmd), 32'(NOP));
    @(negedge clk);
    chk("b2b relaunch bit_cmd", 32'(bit_cmd), 32'(WR));
    wait_done("b2b second");
    write = 0;
    repeat (4) @(negedge clk);

    chk("bit queue drained", 32'(exp_bit_q.size()), 0);
    chk("done queue drained", 32'(exp_done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
- Byte-level sequencer for the I2C bit controller.
- Takes a register-level command (start/write/read/stop flags plus a data byte) and breaks it into the START, WRITE, READ and STOP bit commands, with 8 data bits and 1 ACK bit per byte.
- Sits between the host register file and the bit controller.
- Handles arbitration loss by aborting to idle.

Parameters:
- CMD_NOP, 4'b0000, bit-controller no-op encoding
- CMD_START, 4'b0001, bit-controller START encoding
- CMD_STOP, 4'b0010, bit-controller STOP encoding
- CMD_WRITE, 4'b0100, bit-controller WRITE encoding
- CMD_READ, 4'b1000, bit-controller READ encoding

Ports:
- clk  in  1  system clock
- nReset  in  1  reset; synchronous, active-low
- start  in  1  issue START before the byte
- stop  in  1  issue STOP after the byte
- read  in  1  read a byte
- write  in  1  write a byte
- ack_in  in  1  ACK value driven after a read (0 = ACK, 1 = NACK)
- din  in  8  byte to transmit
- cmd_ack  out  1  one-cycle pulse: command sequence complete
- ack_out  out  1  ACK sampled from the slave after a write (or own ACK after a read)
- dout  out  8  received byte
- bit_cmd  out  4  command to the bit controller
- bit_ack  in  1  bit controller command-complete pulse
- bit_al  in  1  arbitration lost, from the bit controller
- bit_txd  out  1  data bit to the bit controller
- bit_rxd  in  1  data bit from the bit controller

Behaviour:
- Registers and priority
  - All registers update on posedge clk.
  - Priority order: nReset low > bit_al high > normal operation.
- Reset (nReset low at an edge) forces:
  - state = ST_IDLE, bit_cmd = CMD_NOP, bit_txd = 0
  - shift register = 0, dcnt = 0
  - cmd_ack = 0, ack_out = 0
- dout is wired directly to the 8-bit shift register, with no extra latency.
- Launch condition: go = (read | write | stop) & ~cmd_ack.
  - The cmd_ack term blocks re-launch in the cycle when the host sees the pulse.
- cmd_ack is 0 in every cycle except the single completion cycle.
- ST_IDLE, when go is high:
  - Load shift <= din and dcnt <= 7.
  - If start: go to ST_START, bit_cmd = CMD_START.
  - Else if read: go to ST_READ, bit_cmd = CMD_READ.
  - Else if write: go to ST_WRITE, bit_cmd = CMD_WRITE, bit_txd = din[7].
  - Else (stop only): go to ST_STOP, bit_cmd = CMD_STOP.
  - When go is low, hold in ST_IDLE with bit_cmd = CMD_NOP.
- ST_START, on bit_ack:
  - If read: go to ST_READ with CMD_READ.
  - Else: go to ST_WRITE with CMD_WRITE and bit_txd = shift[7].
- ST_WRITE / ST_READ, on each bit_ack:
  - shift <= {shift[6:0], bit_rxd}.
  - If dcnt != 0: dcnt decrements, command repeats, bit_txd = shift[6] (the next MSB).
  - If dcnt == 0: go to ST_ACK.
    - From a read: bit_cmd = CMD_WRITE, bit_txd = ack_in.
    - From a write: bit_cmd = CMD_READ, bit_txd = 1.
- ST_ACK, on bit_ack:
  - ack_out <= bit_rxd.
  - If stop: go to ST_STOP with CMD_STOP.
  - Else: go to ST_IDLE with CMD_NOP and pulse cmd_ack.
- ST_STOP, on bit_ack: go to ST_IDLE, bit_cmd = CMD_NOP, pulse cmd_ack.
- Waiting: without bit_ack, every state holds its state and outputs. Commands are level signals held until bit_ack.
- Arbitration loss (bit_al high):
  - Go to ST_IDLE, bit_cmd = CMD_NOP, cmd_ack = 0 in that cycle.
  - shift and ack_out are held.
  - The host observes the loss via the bit controller's al flag; no cmd_ack is issued.
- Simultaneous bit_ack and bit_al: bit_al wins.
- Host flags are sampled only in ST_IDLE (start, read, write, stop at launch) and at state exits (read, stop, ack_in). They must stay stable until cmd_ack.
  - read and write both high: read wins.
  - start alone, with no read/write/stop: the block stays in ST_IDLE.
- Latency: cmd_ack asserts 1 cycle after the final bit_ack.
- Bit transfer order:
  - Transmit is MSB first.
  - Received bits enter at the LSB, so after 8 bits dout holds the received byte MSB-first.
  - After a write, dout holds the echoed bus bits.

Test Plan:
- Write with START: start=1, write=1, din=8'hA5; bit ctrl model acks each command; slave ACK bit_rxd=0 → bit_cmd sequence START, WRITE×8 with bit_txd 1,0,1,0,0,1,0,1, then READ; ack_out=0; cmd_ack pulses once, 1 cycle after the 10th bit_ack.
- Read with NACK and STOP: read=1, stop=1, ack_in=1; bit_rxd stream 0,1,1,0,1,1,0,0 → READ×8, WRITE with bit_txd=1, STOP; dout=8'h6C; cmd_ack pulses once, after the STOP bit_ack.
- Stop only: stop=1 → a single CMD_STOP; cmd_ack after one bit_ack; dout unchanged.
- Arbitration loss: bit_al=1 in the 3rd WRITE bit, together with bit_ack → next cycle state idle, bit_cmd=0000; no cmd_ack; a new write is then accepted.
- Reset mid-byte: nReset=0 during ST_READ → next edge: bit_cmd=0000, dout=8'h00, ack_out=0, cmd_ack=0; no action until a new command.
- Back-to-back: write held high across cmd_ack → no relaunch in the pulse cycle; the second byte starts the cycle after.
